// File: rtl/cvp_mem_responder.sv
// cvp_mem_responder
//   Memory-side responder for the CVP14 core bus. A word-addressed 16-bit RAM
//   with one-cycle registered reads and writes that commit at the clock edge.
//   It also tracks V-qualified vector bursts and flags protocol violations.
//
//   Optional feature macro: CVP_MEM_BOUNDS_EN
//     defined   - Addr >= DEPTH is out of range: reads return 16'hDEAD,
//                 writes are dropped, and AddrErr pulses.
//     undefined - the address wraps modulo DEPTH and AddrErr is tied to 0.
//
// Ports
//   Clk1      in   1   clock, all state updates on posedge
//   Reset     in   1   synchronous reset, active-low
//   Addr      in   16  word address
//   RD        in   1   read request
//   WR        in   1   write request
//   V         in   1   vector-transfer qualifier
//   WrData    in   16  write data
//   RdData    out  16  read data, held until the next read
//   RdValid   out  1   RdData holds the result of the previous cycle's read
//   BeatCnt   out  5   beats accepted in the current V burst
//   BurstErr  out  1   one-cycle pulse on a burst protocol violation
//   AddrErr   out  1   one-cycle pulse on an out-of-range access
//
// Burst FSM
//   state  | meaning
//   IDLE   | no V burst in progress, BeatCnt = 0
//   RBURST | V-qualified read burst in progress
//   WBURST | V-qualified write burst in progress
module cvp_mem_responder #(
  parameter int DEPTH     = 1024,
  parameter int AW        = 10,
  parameter int MAX_BEATS = 16
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic [15:0] Addr,
  input  logic        RD,
  input  logic        WR,
  input  logic        V,
  input  logic [15:0] WrData,
  output logic [15:0] RdData,
  output logic        RdValid,
  output logic [4:0]  BeatCnt,
  output logic        BurstErr,
  output logic        AddrErr
);

  typedef enum logic [1:0] {IDLE, RBURST, WBURST} burst_state_t;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] mem_idx;
  logic          out_of_range;
  logic          rd_only;
  logic          wr_en;

  burst_state_t  state_q, state_d, want_state;
  logic [4:0]    beat_d;
  logic [15:0]   last_addr_q, last_addr_d;
  logic          burst_err_d;
  logic          addr_same, addr_next;

  assign mem_idx = Addr[AW-1:0];

`ifdef CVP_MEM_BOUNDS_EN
  assign out_of_range = (Addr >> AW) != 16'h0000;
`else
  assign out_of_range = 1'b0;
`endif

  // A simultaneous RD&WR is treated as a write; the read is dropped.
  assign rd_only = RD & ~WR;
  assign wr_en   = WR & ~out_of_range;

  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge Clk1) begin
    if (wr_en) begin
      mem[mem_idx] <= WrData;
    end
  end

  always_ff @(posedge Clk1) begin
    if (!Reset) begin
      RdData  <= 16'h0000;
      RdValid <= 1'b0;
    end else begin
      RdValid <= rd_only;
      if (rd_only) begin
        RdData <= out_of_range ? 16'hDEAD : mem[mem_idx];
      end
    end
  end

`ifdef CVP_MEM_BOUNDS_EN
  always_ff @(posedge Clk1) begin
    if (!Reset) begin
      AddrErr <= 1'b0;
    end else begin
      AddrErr <= out_of_range & (RD | WR);
    end
  end
`else
  assign AddrErr = 1'b0;
`endif

  // Direction the current cycle asks for; RD&WR together never forms a beat.
  always_comb begin
    want_state = IDLE;
    if (V && RD && !WR) begin
      want_state = RBURST;
    end else if (V && WR && !RD) begin
      want_state = WBURST;
    end
  end

  assign addr_same = (Addr == last_addr_q);
  assign addr_next = (Addr == 16'(last_addr_q + 16'd1));

  always_ff @(posedge Clk1) begin
    if (!Reset) begin
      state_q     <= IDLE;
      BeatCnt     <= 5'd0;
      last_addr_q <= 16'h0000;
      BurstErr    <= 1'b0;
    end else begin
      state_q     <= state_d;
      BeatCnt     <= beat_d;
      last_addr_q <= last_addr_d;
      BurstErr    <= burst_err_d;
    end
  end

  // Every transition is decided by the requested direction alone: a valid
  // V beat always lands in its direction's burst state, anything else idles.
  always_comb begin
    state_d = want_state;
  end

  always_comb begin
    beat_d      = BeatCnt;
    last_addr_d = last_addr_q;
    burst_err_d = RD & WR;
    if (want_state == IDLE) begin
      beat_d = 5'd0;
    end else if (state_q != want_state) begin
      // New burst from IDLE, or a direction switch (which is a violation).
      beat_d      = 5'd1;
      last_addr_d = Addr;
      if (state_q != IDLE) begin
        burst_err_d = 1'b1;
      end
    end else if (addr_same) begin
      // The core repeats the first-beat address; not a new beat.
      beat_d = BeatCnt;
    end else if (addr_next) begin
      last_addr_d = Addr;
      if (BeatCnt == 5'(MAX_BEATS)) begin
        burst_err_d = 1'b1;
      end else begin
        beat_d = BeatCnt + 5'd1;
      end
    end else begin
      beat_d      = 5'd1;
      last_addr_d = Addr;
      burst_err_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_cvp_mem_responder.sv
// tb_cvp_mem_responder
//   Self-checking bench for cvp_mem_responder: directed table, hand-written
//   burst sequences and randomized traffic against a queue-based model.
module tb_cvp_mem_responder;

  localparam int DEPTH = 1024;

  logic        Clk1;
  logic        Reset;
  logic [15:0] Addr;
  logic        RD;
  logic        WR;
  logic        V;
  logic [15:0] WrData;
  logic [15:0] RdData;
  logic        RdValid;
  logic [4:0]  BeatCnt;
  logic        BurstErr;
  logic        AddrErr;

  int n_chk  = 0;
  int n_fail = 0;

  cvp_mem_responder #(.DEPTH(DEPTH), .AW(10), .MAX_BEATS(16)) dut (
    .Clk1(Clk1), .Reset(Reset), .Addr(Addr), .RD(RD), .WR(WR), .V(V),
    .WrData(WrData), .RdData(RdData), .RdValid(RdValid), .BeatCnt(BeatCnt),
    .BurstErr(BurstErr), .AddrErr(AddrErr)
  );

  initial Clk1 = 1'b0;
  always #5 Clk1 = ~Clk1;

  // Reference model: memory array plus the accepted beats of the live burst
  // kept as a queue of addresses (window capped at 16 beats).
  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_rdata;
  bit          m_rvalid, m_err, m_aerr;
  int          m_dir;
  logic [15:0] bq [$];

  typedef struct {
    bit          rst;
    logic [15:0] addr;
    bit          rd, wr, v;
    logic [15:0] wd;
    logic [15:0] e_rdata;
    bit          e_rvalid;
    logic [4:0]  e_beats;
    bit          e_err;
    bit          e_aerr;
  } vec_t;

  vec_t tbl [$];

  function automatic logic [15:0] pat(int i);
    return 16'(i * 37 + 4096);
  endfunction

  function automatic vec_t mk(bit rst, logic [15:0] a, bit rd, bit wr, bit v,
                              logic [15:0] wd, logic [15:0] erd, bit erv,
                              logic [4:0] eb, bit ee, bit ea);
    vec_t t;
    t.rst = rst; t.addr = a; t.rd = rd; t.wr = wr; t.v = v; t.wd = wd;
    t.e_rdata = erd; t.e_rvalid = erv; t.e_beats = eb; t.e_err = ee;
    t.e_aerr = ea;
    return t;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(bit rst, logic [15:0] a, bit rd, bit wr, bit v,
                            logic [15:0] wd);
    bit oob;
    int dir;
    int idx;
    if (!rst) begin
      m_rdata = 16'h0000; m_rvalid = 0; m_err = 0; m_aerr = 0;
      bq.delete(); m_dir = 0;
      return;
    end
`ifdef CVP_MEM_BOUNDS_EN
    oob = (int'(a) >= DEPTH);
`else
    oob = 0;
`endif
    idx = int'(a) % DEPTH;
    m_err = rd && wr;
    if (wr && !oob) m_mem[idx] = wd;
    if (rd && !wr) begin
      m_rvalid = 1;
      m_rdata  = oob ? 16'hDEAD : m_mem[idx];
    end else begin
      m_rvalid = 0;
    end
    m_aerr = oob && (rd || wr);
    dir = !v ? 0 : (rd && !wr) ? 1 : (wr && !rd) ? 2 : 0;
    if (dir == 0) begin
      bq.delete(); m_dir = 0;
    end else if (bq.size() == 0) begin
      m_dir = dir; bq.push_back(a);
    end else if (dir != m_dir) begin
      m_err = 1; m_dir = dir; bq.delete(); bq.push_back(a);
    end else if (a == bq[$]) begin
      m_dir = dir;
    end else if (a == 16'(bq[$] + 16'd1)) begin
      bq.push_back(a);
      if (bq.size() > 16) begin
        m_err = 1;
        void'(bq.pop_front());
      end
    end else begin
      m_err = 1; bq.delete(); bq.push_back(a);
    end
  endtask

  // Drive one cycle, let the edge happen, then compare every output to the model.
  task automatic apply(bit rst, logic [15:0] a, bit rd, bit wr, bit v,
                       logic [15:0] wd);
    Reset = rst; Addr = a; RD = rd; WR = wr; V = v; WrData = wd;
    @(posedge Clk1);
    model_step(rst, a, rd, wr, v, wd);
    #1;
    chk("rdata",    RdData,          m_rdata);
    chk("rvalid",   16'(RdValid),    16'(m_rvalid));
    chk("beatcnt",  16'(BeatCnt),    16'(bq.size()));
    chk("bursterr", 16'(BurstErr),   16'(m_err));
    chk("addrerr",  16'(AddrErr),    16'(m_aerr));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] cur;
    logic [15:0] a;
    bit rd, wr, v, rst;
    int r;
    logic [15:0] e405, e_after_wr, e_rd5;
    bit e_aerr_oob;

    Reset = 0; Addr = 0; RD = 0; WR = 0; V = 0; WrData = 0;
    apply(0, 16'h0, 0, 0, 0, 16'h0);
    apply(1, 16'h0, 0, 0, 0, 16'h0);
    for (int i = 0; i < DEPTH; i++) apply(1, 16'(i), 0, 1, 0, pat(i));

`ifdef CVP_MEM_BOUNDS_EN
    e405 = 16'hDEAD; e_after_wr = 16'hDEAD; e_rd5 = 16'hBEEF; e_aerr_oob = 1;
`else
    e405 = 16'hBEEF; e_after_wr = 16'hBEEF; e_rd5 = 16'h7777; e_aerr_oob = 0;
`endif

    //            rst addr     rd wr v  wd        rdata       rv beats err aerr
    tbl.push_back(mk(0, 16'h0007, 0, 0, 0, 16'h0000, 16'h0000,  0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0007, 0, 0, 0, 16'h0000, 16'h0000,  0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0007, 1, 0, 0, 16'h0000, pat(7),    1, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0005, 0, 1, 0, 16'hBEEF, pat(7),    0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0005, 1, 0, 0, 16'h0000, 16'hBEEF,  1, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0005, 0, 0, 0, 16'h0000, 16'hBEEF,  0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0009, 1, 1, 0, 16'h1234, 16'hBEEF,  0, 0, 1, 0));
    tbl.push_back(mk(1, 16'h0009, 1, 0, 0, 16'h0000, 16'h1234,  1, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0405, 1, 0, 0, 16'h0000, e405,      1, 0, 0, e_aerr_oob));
    tbl.push_back(mk(1, 16'h0405, 0, 1, 0, 16'h7777, e_after_wr,0, 0, 0, e_aerr_oob));
    tbl.push_back(mk(1, 16'h0005, 1, 0, 0, 16'h0000, e_rd5,     1, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].v, tbl[i].wd);
      chk("tbl_rdata",    RdData,        tbl[i].e_rdata);
      chk("tbl_rvalid",   16'(RdValid),  16'(tbl[i].e_rvalid));
      chk("tbl_beatcnt",  16'(BeatCnt),  16'(tbl[i].e_beats));
      chk("tbl_bursterr", 16'(BurstErr), 16'(tbl[i].e_err));
      chk("tbl_addrerr",  16'(AddrErr),  16'(tbl[i].e_aerr));
    end

    // Read burst 0x20..0x2F with the first address presented twice.
    apply(1, 16'h0020, 1, 0, 1, 16'h0);
    chk("burst_first", 16'(BeatCnt), 16'd1);
    apply(1, 16'h0020, 1, 0, 1, 16'h0);
    chk("burst_repeat", 16'(BeatCnt), 16'd1);
    chk("burst_repeat_err", 16'(BurstErr), 16'd0);
    for (int k = 1; k < 16; k++) begin
      apply(1, 16'(16'h0020 + k), 1, 0, 1, 16'h0);
      chk("burst_beat", 16'(BeatCnt), 16'(k + 1));
      chk("burst_noerr", 16'(BurstErr), 16'd0);
      chk("burst_data", RdData, pat(32 + k));
    end
    apply(1, 16'h0030, 0, 0, 0, 16'h0);
    chk("burst_end", 16'(BeatCnt), 16'd0);

    // Write burst with a gap in the address sequence.
    apply(1, 16'h0040, 0, 1, 1, 16'hA000);
    apply(1, 16'h0041, 0, 1, 1, 16'hA001);
    chk("wburst_two", 16'(BeatCnt), 16'd2);
    apply(1, 16'h0043, 0, 1, 1, 16'hA003);
    chk("wburst_gap_err", 16'(BurstErr), 16'd1);
    chk("wburst_gap_beat", 16'(BeatCnt), 16'd1);
    apply(1, 16'h0043, 0, 0, 0, 16'h0);
    chk("wburst_err_pulse", 16'(BurstErr), 16'd0);

    // 17 sequential V reads saturate, then reset mid-burst.
    for (int k = 0; k < 17; k++) begin
      apply(1, 16'(16'h0100 + k), 1, 0, 1, 16'h0);
      chk("sat_beat", 16'(BeatCnt), 16'((k < 16) ? k + 1 : 16));
      chk("sat_err", 16'(BurstErr), 16'((k == 16) ? 1 : 0));
    end
    apply(0, 16'h0111, 1, 0, 1, 16'h0);
    chk("rst_mid_beat", 16'(BeatCnt), 16'd0);
    chk("rst_mid_valid", 16'(RdValid), 16'd0);
    apply(1, 16'h0300, 1, 0, 1, 16'h0);
    chk("after_rst_beat", 16'(BeatCnt), 16'd1);
    chk("after_rst_err", 16'(BurstErr), 16'd0);
    apply(1, 16'h0301, 0, 1, 1, 16'h5555);
    chk("dir_switch_err", 16'(BurstErr), 16'd1);
    chk("dir_switch_beat", 16'(BeatCnt), 16'd1);
    apply(1, 16'h0301, 0, 0, 0, 16'h0);

    // Randomized traffic biased toward sequential addresses to form bursts.
    cur = 16'h0000;
    for (int n = 0; n < 2500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      a = 16'(cur + 16'd1);
      else if (r < 65) a = cur;
      else if (r < 85) a = 16'($urandom_range(0, 63));
      else             a = 16'($urandom);
      cur = a;
      r = $urandom_range(0, 99);
      rd = (r < 45) || (r >= 80 && r < 85);
      wr = (r >= 45 && r < 85);
      v  = ($urandom_range(0, 99) < 75);
      if (rd && wr) v = 0;
      rst = ($urandom_range(0, 199) != 0);
      if (!rst) wr = 0;
      apply(rst, a, rd, wr, v, 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
